// File: rtl/frame_transmitter_pkg.sv
//------------------------------------------------------------------------------
// frame_transmitter_pkg
// Definitions shared by the frame transmitter slice:
//   - tx_state_t : transmit FSM state encoding (3 bits)
//   - UART 8N1 line constants (data bits, idle level, start level)
//   - default timing and frame-size parameters
//------------------------------------------------------------------------------
`timescale 1ns/1ps

package frame_transmitter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // 50 MHz system clock, 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_NUM_BYTES    = 16384;
  localparam int DEFAULT_ADDR_W       = 14;

endpackage : frame_transmitter_pkg

// File: rtl/frame_transmitter_if.sv
//------------------------------------------------------------------------------
// frame_transmitter_if
// Bundles the transmitter's controller handshake, output-RAM read port and
// UART line.
//   tx_start     : controller -> transmitter, transmit stage active (level)
//   mem_addr     : transmitter -> RAM, registered read address
//   mem_data     : RAM -> transmitter, synchronous read data (1-cycle latency)
//   tx_serial    : transmitter -> line, UART 8N1, idle high
//   tx_busy      : transmitter -> controller, frame in progress
//   end_transmit : transmitter -> controller, sticky frame-complete flag
// Modports:
//   master : the transmitter itself
//   slave  : the controller / RAM / line side
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface frame_transmitter_if
  import frame_transmitter_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) ();

  logic                 tx_start;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_BITS-1:0] mem_data;
  logic                 tx_serial;
  logic                 tx_busy;
  logic                 end_transmit;

  modport master (
    input  tx_start,
    input  mem_data,
    output mem_addr,
    output tx_serial,
    output tx_busy,
    output end_transmit
  );

  modport slave (
    output tx_start,
    output mem_data,
    input  mem_addr,
    input  tx_serial,
    input  tx_busy,
    input  end_transmit
  );

endinterface : frame_transmitter_if

// File: rtl/frame_transmitter_baud_tick_counter.sv
//------------------------------------------------------------------------------
// baud_tick_counter
// Free-running 0..CLKS_PER_BIT-1 counter that marks the final clock of each
// UART bit period.
//   clock   : system clock
//   reset_n : synchronous active-low reset (count -> 0)
//   clear   : synchronous restart of the bit period (count -> 0)
//   tick    : high for the one cycle in which count == CLKS_PER_BIT-1
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module baud_tick_counter
  import frame_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign tick = (count_reg == LAST_CNT);

  always_comb begin
    count_next = count_reg + CNT_W'(1);
    // clear takes priority so a new state always starts a fresh full bit period
    if (clear || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule : baud_tick_counter

// File: rtl/frame_transmitter.sv
//------------------------------------------------------------------------------
// frame_transmitter
// Transmit engine for the downsampling processor. When the controller holds
// tx_start in IDLE, the engine walks the output RAM from the current address up
// to NUM_BYTES-1, sending each byte as UART 8N1 (start, 8 data LSB first,
// stop). After the last stop bit it parks in DONE with end_transmit high until
// reset.
// Ports:
//   clock   : system clock, all state changes on its rising edge
//   reset_n : synchronous active-low reset; aborts a frame immediately
//   bus     : frame_transmitter_if.master (tx_start, mem_addr, mem_data,
//             tx_serial, tx_busy, end_transmit)
// Byte timing: FETCH(1) + LOAD(1) + 10 bit periods = 10*CLKS_PER_BIT+2 cycles.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module frame_transmitter
  import frame_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int NUM_BYTES    = DEFAULT_NUM_BYTES,
  parameter int ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  frame_transmitter_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t             state_reg,   state_next;
  logic [ADDR_W-1:0]     addr_reg,    addr_next;
  logic [DATA_BITS-1:0]  shift_reg,   shift_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic                  serial_reg,  serial_next;

  logic baud_tick;
  logic baud_clear;

  // Every state change restarts the bit period, so each START/DATA/STOP
  // interval is exactly CLKS_PER_BIT cycles measured from its entry edge.
  assign baud_clear = (state_next != state_reg);

  baud_tick_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (baud_clear),
    .tick    (baud_tick)
  );

  //----------------------------------------------------------------------------
  // State register
  //----------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      serial_reg  <= IDLE_LEVEL;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      serial_reg  <= serial_next;
    end
  end

  //----------------------------------------------------------------------------
  // Next-state and datapath logic
  //----------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    serial_next  = serial_reg;

    unique case (state_reg)
      ST_IDLE: begin
        serial_next = IDLE_LEVEL;
        if (bus.tx_start) begin
          state_next = ST_FETCH;
        end
      end

      // RAM registers mem_addr at the end of this cycle.
      ST_FETCH: begin
        state_next = ST_LOAD;
      end

      // mem_data is valid now; start bit goes out on the same edge.
      ST_LOAD: begin
        shift_next  = bus.mem_data;
        serial_next = START_LEVEL;
        state_next  = ST_START;
      end

      // The shift register is pre-shifted as each bit is launched, so
      // shift_reg[0] always holds the next bit to drive.
      ST_START: begin
        if (baud_tick) begin
          serial_next  = shift_reg[0];
          shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (baud_tick) begin
          if (bit_idx_reg == LAST_BIT) begin
            serial_next = IDLE_LEVEL;
            state_next  = ST_STOP;
          end else begin
            serial_next  = shift_reg[0];
            shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end

      // Address only advances between bytes, never past the last byte.
      ST_STOP: begin
        if (baud_tick) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            addr_next  = addr_reg + ADDR_W'(1);
            state_next = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        serial_next = IDLE_LEVEL;
      end

      default: begin
        serial_next = IDLE_LEVEL;
        state_next  = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign bus.mem_addr     = addr_reg;
  assign bus.tx_serial    = serial_reg;
  assign bus.tx_busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign bus.end_transmit = (state_reg == ST_DONE);

endmodule : frame_transmitter
